// File: rtl/point_add_double.sv
// point_add_double: affine elliptic-curve point add/double over GF(p), built around one shared sequential modular multiplier.
module point_add_double #(
  parameter int n = 231
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         dbl,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  input  logic [n-1:0] x2,
  input  logic [n-1:0] y2,
  input  logic         inf1,
  input  logic         inf2,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         inf3,
  output logic         busy,
  output logic         done
);
  localparam int cw = $clog2(n + 1);
  localparam int kw = $clog2(2 * n);
  typedef enum logic [2:0] {IDLE, CLASSIFY, NUMER, INVERT, LAMBDA, XOUT, YOUT, DONE} state_t;
  state_t state, state_n;
  logic [n-1:0] rp, ra, rx1, ry1, rx2, ry2, u, d, inv, lam, rx3, ry3, ma, mb, acc, e;
  logic [n-1:0] sel_a, sel_b, acc2, acc_n;
  logic rdbl, rinf1, rinf2, rinf;
  logic [cw-1:0] cnt;
  logic [kw-1:0] k;
  logic mul_active, mul_last, eqx, eqy, y0, sp_p2, sp_p1, sp_inf, dbl_eff, special;

  function automatic logic [n-1:0] madd(input logic [n-1:0] x, input logic [n-1:0] y, input logic [n-1:0] m);
    logic [n:0] s, t;
    s = {1'b0, x} + {1'b0, y};
    t = s - {1'b0, m};
    return s >= {1'b0, m} ? t[n-1:0] : s[n-1:0];
  endfunction

  function automatic logic [n-1:0] msub(input logic [n-1:0] x, input logic [n-1:0] y, input logic [n-1:0] m);
    logic [n:0] s, t;
    s = {1'b0, x} + {1'b0, m} - {1'b0, y};
    t = s - {1'b0, m};
    return s >= {1'b0, m} ? t[n-1:0] : s[n-1:0];
  endfunction

  assign mul_active = state inside {NUMER, INVERT, LAMBDA, XOUT, YOUT};
  assign mul_last = mul_active && cnt == cw'(n);
  // interleaved MSB-first step: acc = 2*acc (+ ma) mod p
  assign acc2 = madd(acc, acc, rp);
  assign acc_n = mb[n-1] ? madd(acc2, ma, rp) : acc2;
  // inversion alternates square (even k) and always-multiply by d (odd k)
  assign sel_a = state == NUMER ? rx1 : state == INVERT ? inv : state == LAMBDA ? u : lam;
  assign sel_b = state == NUMER ? rx1 : state == INVERT ? (k[0] ? d : inv) :
                 state == LAMBDA ? inv : state == XOUT ? lam : msub(rx1, rx3, rp);

  assign eqx = rx1 == rx2;
  assign eqy = ry1 == ry2;
  assign y0 = ry1 == '0;
  assign sp_p2 = !rdbl && rinf1;
  assign sp_p1 = !rdbl && !rinf1 && rinf2;
  assign dbl_eff = rdbl || (eqx && eqy);
  // a promoted add with y1 = 0 is P + (-P), so it is caught here too
  assign sp_inf = !sp_p2 && !sp_p1 && (rdbl ? (rinf1 || y0) : (eqx && (!eqy || y0)));
  assign special = sp_p2 || sp_p1 || sp_inf;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = start ? CLASSIFY : IDLE;
      CLASSIFY: state_n = special ? DONE : NUMER;
      NUMER:    state_n = mul_last ? INVERT : NUMER;
      INVERT:   state_n = mul_last && k == kw'(2 * n - 1) ? LAMBDA : INVERT;
      LAMBDA:   state_n = mul_last ? XOUT : LAMBDA;
      XOUT:     state_n = mul_last ? YOUT : XOUT;
      YOUT:     state_n = mul_last ? DONE : YOUT;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      {rp, ra, rx1, ry1, rx2, ry2, u, d, inv, lam, rx3, ry3, ma, mb, acc, e} <= '0;
      {rdbl, rinf1, rinf2, rinf, cnt, k} <= '0;
      {x3, y3, inf3, busy, done} <= '0;
    end else begin
      done <= state == DONE;
      busy <= start || state != IDLE;
      if (state == DONE) {x3, y3, inf3} <= {rx3, ry3, rinf};
      cnt <= mul_active && !mul_last ? cnt + 1'b1 : '0;
      if (mul_active && cnt == '0) {ma, mb, acc} <= {sel_a, sel_b, {n{1'b0}}};
      else if (mul_active) {mb, acc} <= {mb << 1, acc_n};
      case (state)
        IDLE: if (start) begin
          {rp, ra, rx1, ry1, rx2, ry2} <= {p, a, x1, y1, x2, y2};
          {rdbl, rinf1, rinf2} <= {dbl, inf1, inf2};
        end
        CLASSIFY: begin
          rx3 <= sp_p2 ? (rinf2 ? '0 : rx2) : sp_p1 ? rx1 : '0;
          ry3 <= sp_p2 ? (rinf2 ? '0 : ry2) : sp_p1 ? ry1 : '0;
          rinf <= sp_inf || (sp_p2 && rinf2);
          rdbl <= dbl_eff;
          e <= rp - n'(2);
        end
        NUMER: if (mul_last) begin
          u <= rdbl ? madd(madd(madd(acc_n, acc_n, rp), acc_n, rp), ra, rp) : msub(ry2, ry1, rp);
          d <= rdbl ? madd(ry1, ry1, rp) : msub(rx2, rx1, rp);
          inv <= n'(1);
          k <= '0;
        end
        INVERT: if (mul_last) begin
          inv <= k[0] && !e[n-1] ? inv : acc_n;
          if (k[0]) e <= e << 1;
          k <= k + 1'b1;
        end
        LAMBDA: if (mul_last) lam <= acc_n;
        XOUT: if (mul_last) rx3 <= msub(msub(acc_n, rx1, rp), rdbl ? rx1 : rx2, rp);
        YOUT: if (mul_last) ry3 <= msub(acc_n, ry1, rp);
        default: ;
      endcase
    end
  end
endmodule
